tm_engine: RTL and testbench

Parametrised successor to the fixed 4-bit/64-cell Turing machine behind the chip top. It adds a programmable transition table loaded nibble-serially, configurable symbol/state/tape sizes, bounded execution with error reporting, and a tape read-back display phase. It sits directly under the chip top, driven by the data nibble and the Next/Done buttons.

---
 rtl/tm_pkg.sv | 48 ++++
 rtl/tm_engine_if.sv | 33 +++
 rtl/tm_btn_edge.sv | 24 ++
 rtl/tm_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_tm_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tm_pkg                                                          |
// | Purpose  : Shared types and helpers for the programmable Turing machine:   |
// |            phase and error encodings, nibbles-per-entry calculation and    |
// |            transition-entry field offsets derived from SYM_W / STATE_W.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tm_pkg;

  typedef enum logic [1:0] {
    LOAD_PROG = 2'b00,
    LOAD_TAPE = 2'b01,
    RUN       = 2'b10,
    SHOW      = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_LEFT    = 2'b01,
    ERR_RIGHT   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  // Entry = {halt, next_state, dir, write_sym}
  function automatic int entry_width(input int sym_w, input int state_w);
    return sym_w + 1 + state_w + 1;
  endfunction

  function automatic int nib_count(input int entry_w, input int data_w);
    return (entry_w + data_w - 1) / data_w;
  endfunction

  function automatic int dir_bit(input int sym_w);
    return sym_w;
  endfunction

  function automatic int next_state_lsb(input int sym_w);
    return sym_w + 1;
  endfunction

  function automatic int halt_bit(input int sym_w, input int state_w);
    return sym_w + 1 + state_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tm_engine_if                                                    |
// | Purpose  : Button/data/display bundle between the chip top and tm_engine.  |
// | Ports    : input_data (program nibbles / tape symbols), Next, Done (level  |
// |            buttons), display_out {phase, index, symbol}, Compute_done,     |
// |            err (halt cause).                                               |
// |            master = driver side, slave = engine side.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface tm_engine_if #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 6,
  parameter int SYM_W  = 2
);
  logic [DATA_W-1:0]         input_data;
  logic                      Next;
  logic                      Done;
  logic [2+IDX_W+SYM_W-1:0]  display_out;
  logic                      Compute_done;
  logic [1:0]                err;

  modport master (
    output input_data, Next, Done,
    input  display_out, Compute_done, err
  );

  modport slave (
    input  input_data, Next, Done,
    output display_out, Compute_done, err
  );
endinterface
`default_nettype wire

// File: rtl/tm_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tm_btn_edge                                                     |
// | Purpose  : Level-to-pulse converter; one-cycle pulse per rising edge.      |
// | Ports    : clock, reset (sync, active-high), level_i (button level),       |
// |            pulse_o (high for the cycle in which level_i first reads 1).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tm_btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);
  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;
endmodule
`default_nettype wire

// File: rtl/tm_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tm_engine                                                       |
// | Purpose  : Programmable Turing machine. Transition table loaded nibble-    |
// |            serially, tape loaded symbol-serially, bounded execution with   |
// |            halt-cause reporting, then tape read-back.                      |
// | Ports    : clock, reset (sync, active-high), bus (tm_engine_if.slave):     |
// |            input_data, Next, Done in; display_out, Compute_done, err out.  |
// | Options  : STEP_MODE_EN - when defined, RUN performs one transition per    |
// |            Next pulse instead of one per clock.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tm_engine
  import tm_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int SYM_W     = 2,
  parameter int STATE_W   = 2,
  parameter int TAPE_LEN  = 64,
  parameter int MAX_STEPS = 1023
) (
  input  logic        clock,
  input  logic        reset,
  tm_engine_if.slave  bus
);
  localparam int IDX_W   = $clog2(TAPE_LEN);
  localparam int ENTRY_W = entry_width(SYM_W, STATE_W);
  localparam int NIB     = nib_count(ENTRY_W, DATA_W);
  localparam int BUF_W   = NIB * DATA_W;
  localparam int NC_W    = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int TBL_AW  = STATE_W + SYM_W;
  localparam int N_ENT   = 2 ** TBL_AW;
  localparam int STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int DIR_B   = dir_bit(SYM_W);
  localparam int NS_LSB  = next_state_lsb(SYM_W);
  localparam int HALT_B  = halt_bit(SYM_W, STATE_W);
  localparam logic [ENTRY_W-1:0] ENTRY_RST = {1'b1, {(ENTRY_W-1){1'b0}}};

  // Button pulses; Done wins a same-cycle collision
  logic next_raw, next_p, done_p;
  tm_btn_edge u_next_edge (.clock(clock), .reset(reset), .level_i(bus.Next), .pulse_o(next_raw));
  tm_btn_edge u_done_edge (.clock(clock), .reset(reset), .level_i(bus.Done), .pulse_o(done_p));
  assign next_p = next_raw & ~done_p;

  phase_t              phase_q, phase_d;
  err_t                err_q, err_d;
  logic [ENTRY_W-1:0]  table_q [N_ENT];
  logic [SYM_W-1:0]    tape_q  [TAPE_LEN];
  logic [BUF_W-1:0]    nib_buf_q, nib_buf_d;
  logic [NC_W-1:0]     nib_cnt_q, nib_cnt_d;
  logic [TBL_AW:0]     eptr_q, eptr_d;   // extra MSB flags "table full"
  logic [IDX_W:0]      wptr_q, wptr_d;   // can reach TAPE_LEN
  logic [IDX_W-1:0]    head_q, head_d, rptr_q, rptr_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d;

  logic                tbl_we, tape_we, tape_clr;
  logic [ENTRY_W-1:0]  tbl_wdata;
  logic [IDX_W-1:0]    tape_waddr;
  logic [SYM_W-1:0]    tape_wdata;
  logic [BUF_W-1:0]    full_word;
  logic [SYM_W-1:0]    head_sym;
  logic [ENTRY_W-1:0]  cur_entry;
  logic [STEP_W-1:0]   steps_inc;
  logic                run_step;

  assign head_sym  = tape_q[head_q];
  assign cur_entry = table_q[{state_q, head_sym}];
  assign steps_inc = steps_q + 1'b1;

`ifdef STEP_MODE_EN
  assign run_step = next_p;
`else
  assign run_step = 1'b1;
`endif

  // Completed entry: buffered low nibbles plus the nibble arriving now
  always_comb begin
    full_word = nib_buf_q;
    full_word[(NIB-1)*DATA_W +: DATA_W] = bus.input_data;
  end
  assign tbl_wdata = full_word[ENTRY_W-1:0];

  generate
    if (BUF_W > ENTRY_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^full_word[BUF_W-1:ENTRY_W];
    end
  endgenerate

  always_comb begin
    phase_d    = phase_q;
    err_d      = err_q;
    nib_buf_d  = nib_buf_q;
    nib_cnt_d  = nib_cnt_q;
    eptr_d     = eptr_q;
    wptr_d     = wptr_q;
    head_d     = head_q;
    rptr_d     = rptr_q;
    state_d    = state_q;
    steps_d    = steps_q;
    tbl_we     = 1'b0;
    tape_we    = 1'b0;
    tape_clr   = 1'b0;
    tape_waddr = head_q;
    tape_wdata = cur_entry[SYM_W-1:0];
    case (phase_q)
      LOAD_PROG: begin
        if (done_p) begin
          phase_d   = LOAD_TAPE;
          nib_cnt_d = '0;
        end else if (next_p && !eptr_q[TBL_AW]) begin
          if (nib_cnt_q == NC_W'(NIB - 1)) begin
            tbl_we    = 1'b1;
            eptr_d    = eptr_q + 1'b1;
            nib_cnt_d = '0;
          end else begin
            nib_buf_d[int'(nib_cnt_q)*DATA_W +: DATA_W] = bus.input_data;
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end
      end
      LOAD_TAPE: begin
        if (done_p) begin
          phase_d = RUN;
          head_d  = '0;
          state_d = '0;
          steps_d = '0;
          err_d   = ERR_OK;
        end else if (next_p && (wptr_q < (IDX_W+1)'(TAPE_LEN))) begin
          tape_we    = 1'b1;
          tape_waddr = wptr_q[IDX_W-1:0];
          tape_wdata = bus.input_data[SYM_W-1:0];
          wptr_d     = wptr_q + 1'b1;
        end
      end
      RUN: begin
        rptr_d = '0;
        if (run_step) begin
          tape_we = 1'b1;
          steps_d = steps_inc;
          if (cur_entry[HALT_B]) begin
            phase_d = SHOW;
            err_d   = ERR_OK;
          end else if (!cur_entry[DIR_B] && (head_q == '0)) begin
            phase_d = SHOW;
            err_d   = ERR_LEFT;
          end else if (cur_entry[DIR_B] && (head_q == IDX_W'(TAPE_LEN - 1))) begin
            phase_d = SHOW;
            err_d   = ERR_RIGHT;
          end else begin
            head_d  = cur_entry[DIR_B] ? head_q + 1'b1 : head_q - 1'b1;
            state_d = cur_entry[NS_LSB +: STATE_W];
            if (steps_inc == STEP_W'(MAX_STEPS)) begin
              phase_d = SHOW;
              err_d   = ERR_TIMEOUT;
            end
          end
        end
      end
      SHOW: begin
        if (done_p) begin
          phase_d  = LOAD_TAPE;
          tape_clr = 1'b1;
          err_d    = ERR_OK;
          wptr_d   = '0;
        end else if (next_p) begin
          rptr_d = (rptr_q == IDX_W'(TAPE_LEN - 1)) ? '0 : rptr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q   <= LOAD_PROG;
      err_q     <= ERR_OK;
      nib_buf_q <= '0;
      nib_cnt_q <= '0;
      eptr_q    <= '0;
      wptr_q    <= '0;
      head_q    <= '0;
      rptr_q    <= '0;
      state_q   <= '0;
      steps_q   <= '0;
      for (int i = 0; i < N_ENT; i++)    table_q[i] <= ENTRY_RST;
      for (int i = 0; i < TAPE_LEN; i++) tape_q[i]  <= '0;
    end else begin
      phase_q   <= phase_d;
      err_q     <= err_d;
      nib_buf_q <= nib_buf_d;
      nib_cnt_q <= nib_cnt_d;
      eptr_q    <= eptr_d;
      wptr_q    <= wptr_d;
      head_q    <= head_d;
      rptr_q    <= rptr_d;
      state_q   <= state_d;
      steps_q   <= steps_d;
      if (tbl_we) table_q[eptr_q[TBL_AW-1:0]] <= tbl_wdata;
      if (tape_clr) begin
        for (int i = 0; i < TAPE_LEN; i++) tape_q[i] <= '0;
      end else if (tape_we) begin
        tape_q[tape_waddr] <= tape_wdata;
      end
    end
  end

  logic [IDX_W-1:0] disp_idx;
  logic [SYM_W-1:0] disp_sym;

  always_comb begin
    disp_idx = '0;
    disp_sym = '0;
    case (phase_q)
      LOAD_PROG: begin
        disp_idx = IDX_W'(eptr_q);
        disp_sym = SYM_W'(nib_cnt_q);
      end
      LOAD_TAPE: begin
        disp_idx = IDX_W'(wptr_q);
        disp_sym = bus.input_data[SYM_W-1:0];
      end
      RUN: begin
        disp_idx = head_q;
        disp_sym = head_sym;
      end
      SHOW: begin
        disp_idx = rptr_q;
        disp_sym = tape_q[rptr_q];
      end
      default: ;
    endcase
  end

  assign bus.display_out  = {phase_q, disp_idx, disp_sym};
  assign bus.Compute_done = (phase_q == SHOW);
  assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tm_engine.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_tm_engine                                                    |
// | Purpose  : Self-checking bench for tm_engine (default build) with a        |
// |            behavioural Turing-machine reference model.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tm_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tm_engine_if #(.DATA_W(4), .IDX_W(6), .SYM_W(2)) bus ();

  tm_engine #(
    .DATA_W(4), .SYM_W(2), .STATE_W(2), .TAPE_LEN(64), .MAX_STEPS(1023)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  wire [1:0] d_ph  = bus.display_out[9:8];
  wire [5:0] d_idx = bus.display_out[7:2];
  wire [1:0] d_sym = bus.display_out[1:0];

  int n_checks = 0;
  int n_pass   = 0;

  int m_prog[16];
  int m_tape[64];
  int m_raw[64];
  int obs_tape[64];
  int obs_idx_bad;
  int m_steps, m_err, m_lhead;
  int o_cycles, o_lhead;
  bit o_reached;

  // ---------------- stimulus helpers (drive at negedge) ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bus.Next = 1'b0; bus.Done = 1'b0; bus.input_data = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input bit nx, input bit dn, input logic [3:0] d);
    @(negedge clk);
    bus.input_data = d; bus.Next = nx; bus.Done = dn;
    @(negedge clk);
    bus.Next = 1'b0; bus.Done = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_prog[i] = 32;
    for (int i = 0; i < 64; i++) begin m_tape[i] = 0; m_raw[i] = 0; end
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      press(1'b1, 1'b0, 4'(m_prog[i] & 15));
      press(1'b1, 1'b0, 4'(m_prog[i] >> 4));
    end
    press(1'b0, 1'b1, 4'h0);
  endtask

  task automatic load_tape(input int n);
    for (int i = 0; i < n; i++) begin
      press(1'b1, 1'b0, 4'(m_raw[i]));
      m_tape[i] = m_raw[i] % 4;
    end
  endtask

  // Reference machine: plain interpretation of the transition rules
  task automatic model_run();
    int head, st, sym, e, ws, dir, ns, halt;
    head = 0; st = 0; m_steps = 0; m_err = 0; m_lhead = 0;
    forever begin
      sym  = m_tape[head];
      e    = m_prog[st * 4 + sym];
      ws   = e % 4;
      dir  = (e / 4) % 2;
      ns   = (e / 8) % 4;
      halt = (e / 32) % 2;
      m_lhead = head;
      m_tape[head] = ws;
      m_steps++;
      if (halt == 1) begin m_err = 0; break; end
      if (dir == 0 && head == 0)  begin m_err = 1; break; end
      if (dir == 1 && head == 63) begin m_err = 2; break; end
      head = (dir == 1) ? head + 1 : head - 1;
      st = ns;
      if (m_steps == 1023) begin m_err = 3; break; end
    end
  endtask

  // Counts RUN cycles until SHOW appears; bounded
  task automatic observe_run();
    o_cycles = 0; o_lhead = -1; o_reached = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (d_ph == 2'b11) begin o_reached = 1'b1; break; end
      if (d_ph == 2'b10) begin o_cycles++; o_lhead = int'(d_idx); end
      @(negedge clk);
    end
  endtask

  task automatic read_tape();
    obs_idx_bad = 0;
    for (int i = 0; i < 64; i++) begin
      obs_tape[i] = int'(d_sym);
      if (d_idx != 6'(i)) obs_idx_bad++;
      press(1'b1, 1'b0, 4'h0);
    end
  endtask

  function automatic int tape_bad(output int first);
    int nb;
    nb = obs_idx_bad; first = 0;
    for (int i = 63; i >= 0; i--)
      if (obs_tape[i] != m_tape[i]) begin nb++; first = i; end
    return nb;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.display_out !== 10'h000) $display("FAIL reset display: got %h expected 000", bus.display_out);
    else n_pass++;
    n_checks++;
    if (bus.Compute_done !== 1'b0) $display("FAIL reset Compute_done: got %b expected 0", bus.Compute_done);
    else n_pass++;
    n_checks++;
    if (bus.err !== 2'b00) $display("FAIL reset err: got %b expected 00", bus.err);
    else n_pass++;
  endtask

  task automatic test_unary();
    int nb, fi;
    model_clear();
    m_prog[0] = 'h25; m_prog[1] = 'h05;
    apply_reset();
    press(1'b1, 1'b0, 4'h5);
    n_checks++;
    if (bus.display_out !== {2'b00, 6'd0, 2'd1})
      $display("FAIL prog nibble display: got %h expected %h", bus.display_out, {2'b00, 6'd0, 2'd1});
    else n_pass++;
    press(1'b1, 1'b0, 4'h2);
    press(1'b1, 1'b0, 4'h5);
    press(1'b1, 1'b0, 4'h0);
    n_checks++;
    if (bus.display_out !== {2'b00, 6'd2, 2'd0})
      $display("FAIL prog entry display: got %h expected %h", bus.display_out, {2'b00, 6'd2, 2'd0});
    else n_pass++;
    press(1'b0, 1'b1, 4'h0);
    m_raw[0] = 5; m_raw[1] = 9; m_raw[2] = 13;   // upper data bits must be ignored
    load_tape(3);
    n_checks++;
    if (d_ph !== 2'b01 || d_idx !== 6'd3)
      $display("FAIL tape load display: got phase %b idx %0d expected 01/3", d_ph, d_idx);
    else n_pass++;
    press(1'b0, 1'b1, 4'h0);
    model_run();
    observe_run();
    n_checks++;
    if (!o_reached || o_cycles != 4)
      $display("FAIL unary transitions: got %0d (show=%0d) expected 4", o_cycles, o_reached);
    else n_pass++;
    n_checks++;
    if (bus.err !== 2'b00 || bus.Compute_done !== 1'b1)
      $display("FAIL unary status: got err %b done %b expected 00/1", bus.err, bus.Compute_done);
    else n_pass++;
    read_tape();
    nb = tape_bad(fi);
    n_checks++;
    if (nb != 0) $display("FAIL unary tape: %0d bad, cell %0d got %0d expected %0d", nb, fi, obs_tape[fi], m_tape[fi]);
    else n_pass++;
  endtask

  task automatic test_right_edge();
    int nb, fi;
    model_clear();
    m_prog[0] = 'h04;
    apply_reset();
    load_prog(1);
    press(1'b0, 1'b1, 4'h0);
    model_run();
    observe_run();
    n_checks++;
    if (!o_reached || o_cycles != 64)
      $display("FAIL right transitions: got %0d expected 64", o_cycles);
    else n_pass++;
    n_checks++;
    if (bus.err !== 2'b10) $display("FAIL right err: got %b expected 10", bus.err);
    else n_pass++;
    n_checks++;
    if (o_lhead != 63) $display("FAIL right head: got %0d expected 63", o_lhead);
    else n_pass++;
    read_tape();
    nb = tape_bad(fi);
    n_checks++;
    if (nb != 0) $display("FAIL right tape: %0d bad, cell %0d got %0d expected %0d", nb, fi, obs_tape[fi], m_tape[fi]);
    else n_pass++;
  endtask

  task automatic test_left_edge();
    int nb, fi;
    model_clear();
    m_prog[0] = 'h02;
    apply_reset();
    load_prog(1);
    press(1'b0, 1'b1, 4'h0);
    model_run();
    observe_run();
    n_checks++;
    if (!o_reached || o_cycles != 1 || bus.err !== 2'b01)
      $display("FAIL left halt: got %0d steps err %b expected 1 steps err 01", o_cycles, bus.err);
    else n_pass++;
    read_tape();
    nb = tape_bad(fi);
    n_checks++;
    if (nb != 0 || obs_tape[0] != 2)
      $display("FAIL left tape: %0d bad, cell0 got %0d expected 2", nb, obs_tape[0]);
    else n_pass++;
  endtask

  task automatic test_timeout();
    model_clear();
    m_prog[0] = 'h0C; m_prog[4] = 'h00;
    apply_reset();
    load_prog(5);
    press(1'b0, 1'b1, 4'h0);
    observe_run();
    n_checks++;
    if (!o_reached || o_cycles != 1023)
      $display("FAIL timeout transitions: got %0d expected 1023", o_cycles);
    else n_pass++;
    n_checks++;
    if (bus.err !== 2'b11) $display("FAIL timeout err: got %b expected 11", bus.err);
    else n_pass++;
  endtask

  task automatic test_buttons();
    apply_reset();
    press(1'b0, 1'b1, 4'h0);          // empty program
    press(1'b1, 1'b0, 4'h3);          // tape[0]=3
    press(1'b1, 1'b1, 4'h2);          // collision: Done only
    n_checks++;
    if (d_ph !== 2'b10) $display("FAIL collision phase: got %b expected 10", d_ph);
    else n_pass++;
    @(negedge clk);                   // empty program halts in one step
    press(1'b1, 1'b0, 4'h0);          // rptr=1
    n_checks++;
    if (d_ph !== 2'b11 || d_idx !== 6'd1 || d_sym !== 2'd0)
      $display("FAIL collision tape1: got ph %b idx %0d sym %0d expected 11/1/0", d_ph, d_idx, d_sym);
    else n_pass++;
    for (int i = 0; i < 64; i++) press(1'b1, 1'b0, 4'h0);
    n_checks++;
    if (d_idx !== 6'd1) $display("FAIL show wrap: got rptr %0d expected 1", d_idx);
    else n_pass++;
    press(1'b0, 1'b1, 4'h0);
    n_checks++;
    if (d_ph !== 2'b01 || d_idx !== 6'd0 || bus.Compute_done !== 1'b0 || bus.err !== 2'b00)
      $display("FAIL show exit: got ph %b idx %0d done %b err %b expected 01/0/0/00",
               d_ph, d_idx, bus.Compute_done, bus.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    model_clear();
    m_prog[0] = 'h0C; m_prog[4] = 'h00;
    apply_reset();
    load_prog(5);
    press(1'b0, 1'b1, 4'h0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.display_out !== 10'h000 || bus.Compute_done !== 1'b0 || bus.err !== 2'b00)
      $display("FAIL midrun reset: got disp %h done %b err %b expected 000/0/00",
               bus.display_out, bus.Compute_done, bus.err);
    else n_pass++;
    press(1'b0, 1'b1, 4'h0);
    press(1'b0, 1'b1, 4'h0);
    observe_run();
    n_checks++;
    if (!o_reached || o_cycles != 1 || bus.err !== 2'b00)
      $display("FAIL midrun table cleared: got %0d steps err %b expected 1 steps err 00", o_cycles, bus.err);
    else n_pass++;
  endtask

  task automatic test_random();
    int n_ent, n_tape, nb, fi;
    for (int it = 0; it < 6; it++) begin
      model_clear();
      n_ent = $urandom_range(0, 16);
      for (int i = 0; i < n_ent; i++)
        m_prog[i] = $urandom_range(0, 31) + (($urandom_range(0, 5) == 0) ? 32 : 0);
      n_tape = $urandom_range(0, 64);
      for (int i = 0; i < n_tape; i++) m_raw[i] = $urandom_range(0, 15);
      apply_reset();
      load_prog(n_ent);
      load_tape(n_tape);
      press(1'b0, 1'b1, 4'h0);
      model_run();
      observe_run();
      n_checks++;
      if (!o_reached || o_cycles != m_steps)
        $display("FAIL rand%0d steps: got %0d expected %0d", it, o_cycles, m_steps);
      else n_pass++;
      n_checks++;
      if (bus.err !== 2'(m_err)) $display("FAIL rand%0d err: got %b expected %0d", it, bus.err, m_err);
      else n_pass++;
      n_checks++;
      if (o_lhead != m_lhead) $display("FAIL rand%0d head: got %0d expected %0d", it, o_lhead, m_lhead);
      else n_pass++;
      read_tape();
      nb = tape_bad(fi);
      n_checks++;
      if (nb != 0)
        $display("FAIL rand%0d tape: %0d bad, cell %0d got %0d expected %0d", it, nb, fi, obs_tape[fi], m_tape[fi]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.input_data = 4'h0;
    bus.Next = 1'b0;
    bus.Done = 1'b0;
    test_reset();
    test_unary();
    test_right_edge();
    test_left_edge();
    test_timeout();
    test_buttons();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
